cpu_monitor: RTL

CPU_MONITOR -- requirements
Module: cpu_monitor

---
 rtl/cpu_monitor_pkg.sv | 27 ++
 rtl/cpu_monitor_hex_to_seg.sv | 16 +
 rtl/cpu_monitor.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_monitor_pkg.sv
// ---------------------------------------------------------------------------
// cpu_monitor_pkg
// Shared definitions for the CPU single-step / 7-segment monitor:
//   - N_DIGITS : number of multiplexed display digits
//   - sel_e    : encoding of the 'sel' input (which CPU value is shown)
//   - HEX_SEG  : 16-entry hex-to-segment table, active-low {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
package cpu_monitor_pkg;

  localparam int N_DIGITS = 4;

  typedef enum logic [1:0] {
    SEL_PC   = 2'b00,  // currentAdd[15:0]
    SEL_REGS = 2'b01,  // {readData1[7:0], readData2[7:0]}
    SEL_WB   = 2'b10,  // {Result[7:0], writeData[7:0]}
    SEL_OP   = 2'b11   // o_p[15:0]
  } sel_e;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,  // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,  // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,  // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E   // C d E F
  };

endpackage

// File: rtl/cpu_monitor_hex_to_seg.sv
// ---------------------------------------------------------------------------
// hex_to_seg
// Combinational hex nibble to 7-segment decoder (active-low outputs).
//   i_nibble : 4-bit hex value
//   o_seg    : segments {g,f,e,d,c,b,a}, 0 = lit
// ---------------------------------------------------------------------------
module hex_to_seg
  import cpu_monitor_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_SEG[i_nibble];

endmodule

// File: rtl/cpu_monitor.sv
// ---------------------------------------------------------------------------
// cpu_monitor
// Debounces a single-step push button to produce the CPU clock and a
// one-cycle step pulse, and multiplexes a 16-bit CPU observation value onto
// a 4-digit active-low 7-segment display.
//
// Ports
//   CLK        : system clock (all state on rising edge)
//   Reset      : asynchronous, active-low reset
//   btn        : raw single-step button
//   sel        : display source select (see sel_e)
//   currentAdd, readData1, readData2, Result, writeData, o_p : CPU buses
//   cpu_clk    : debounced button level
//   step_pulse : one-cycle pulse per accepted press
//   an         : digit enables, active-low one-hot (an[0] = rightmost)
//   seg        : segments {dp,g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module cpu_monitor
  import cpu_monitor_pkg::*;
#(
  parameter int DB_CNT   = 1000000,
  parameter int SCAN_CNT = 100000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        btn,
  input  logic [1:0]  sel,
  input  logic [31:0] currentAdd,
  input  logic [31:0] readData1,
  input  logic [31:0] readData2,
  input  logic [31:0] Result,
  input  logic [31:0] writeData,
  input  logic [31:0] o_p,
  output logic        cpu_clk,
  output logic        step_pulse,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  localparam int DB_W  = (DB_CNT   > 1) ? $clog2(DB_CNT)   : 1;
  localparam int SC_W  = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
  localparam int DIG_W = $clog2(N_DIGITS);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DB_CNT - 1);
  localparam logic [SC_W-1:0]  SC_LAST    = SC_W'(SCAN_CNT - 1);
  localparam logic [DIG_W-1:0] LAST_DIGIT = DIG_W'(N_DIGITS - 1);

  // Button path
  logic            r_sync0;
  logic            r_sync1;
  logic            r_stable;
  logic [DB_W-1:0] r_db_cnt;
  logic            r_step;
  logic            w_db_accept;

  // Display path
  logic [SC_W-1:0]  r_scan_cnt;
  logic [DIG_W-1:0] r_digit;
  logic [15:0]      r_disp;
  logic             r_dp_flag;
  logic [3:0]       r_an;
  logic [7:0]       r_seg;
  logic             w_scan_wrap;
  logic             w_frame_wrap;
  logic [15:0]      w_sel_value;
  logic [3:0]       w_nibble;
  logic [6:0]       w_seg7;

  // Only the low bytes/halves of the CPU buses are displayed.
  logic w_unused_bits;
  assign w_unused_bits = ^{currentAdd[31:16], readData1[31:8], readData2[31:8],
                           Result[31:8], writeData[31:8], o_p[31:16]};

  // -------------------------------------------------------------------------
  // Two-flop synchronizer for the asynchronous button.
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
    end else begin
      r_sync0 <= btn;
      r_sync1 <= r_sync0;
    end
  end

  // -------------------------------------------------------------------------
  // Debounce: the counter measures how long the synchronized level has
  // disagreed with the stable level; any agreement restarts the measurement,
  // so glitches shorter than DB_CNT cycles never reach r_stable.
  // -------------------------------------------------------------------------
  assign w_db_accept = (r_sync1 != r_stable) && (r_db_cnt == DB_LAST);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_stable <= 1'b0;
      r_db_cnt <= '0;
      r_step   <= 1'b0;
    end else begin
      // Pulse only on a 0->1 acceptance, coincident with cpu_clk rising.
      r_step <= w_db_accept && r_sync1;
      if (r_sync1 == r_stable) begin
        r_db_cnt <= '0;
      end else if (w_db_accept) begin
        r_stable <= r_sync1;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  assign cpu_clk    = r_stable;
  assign step_pulse = r_step;

  // -------------------------------------------------------------------------
  // Digit scan and frame-boundary latch of the displayed value.
  // -------------------------------------------------------------------------
  assign w_scan_wrap  = (r_scan_cnt == SC_LAST);
  assign w_frame_wrap = w_scan_wrap && (r_digit == LAST_DIGIT);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_sel_value = currentAdd[15:0];
    case (sel_e'(sel))
      SEL_PC:   w_sel_value = currentAdd[15:0];
      SEL_REGS: w_sel_value = {readData1[7:0], readData2[7:0]};
      SEL_WB:   w_sel_value = {Result[7:0], writeData[7:0]};
      SEL_OP:   w_sel_value = o_p[15:0];
      default:  w_sel_value = currentAdd[15:0];
    endcase
  end

  // NOTE: the display register is datapath, but it is reset anyway so the
  // first frame after reset shows a defined value (0000) instead of X.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_scan_cnt <= '0;
      r_digit    <= '0;
      r_disp     <= '0;
      r_dp_flag  <= 1'b0;
    end else begin
      r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + SC_W'(1);
      if (w_scan_wrap) begin
        r_digit <= r_digit + DIG_W'(1);  // N_DIGITS is a power of two
      end
      // Latching only at the 3->0 boundary keeps a frame tear-free.
      if (w_frame_wrap) begin
        r_disp <= w_sel_value;
      end
      // dp flag tracks "a step happened in this frame"; the boundary wins.
      if (w_frame_wrap) begin
        r_dp_flag <= 1'b0;
      end else if (r_step) begin
        r_dp_flag <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registered digit drive: one cycle behind the digit index.
  // -------------------------------------------------------------------------
  assign w_nibble = r_disp[{r_digit, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .i_nibble (w_nibble),
    .o_seg    (w_seg7)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_an  <= 4'b1111;
      r_seg <= 8'hFF;
    end else begin
      r_an  <= ~(4'b0001 << r_digit);
      r_seg <= {~((r_digit == '0) && r_dp_flag), w_seg7};
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

endmodule
